// File: rtl/ras_ctrl.sv
// Return-address-stack sequencing controller: classifies accepted control-flow
// instructions, emits registered RAS/checkpoint strobes. Optional macro: RAS_CTRL_COMPRESSED_EN.
module ras_ctrl #(
   parameter int MAX_IDS = 8,
   parameter int CNT_W   = $clog2(MAX_IDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_valid,
   output logic             fetch_ready,
   input  logic [31:0]      fetch_pc,
   input  logic             is_branch,
   input  logic             is_jal,
   input  logic             is_jalr,
   input  logic [4:0]       rd_addr,
   input  logic [4:0]       rs1_addr,
`ifdef RAS_CTRL_COMPRESSED_EN
   input  logic             is_compressed,
`endif
   input  logic             branch_retired,
   input  logic             fetch_flush,
   input  logic             early_flush,
   output logic             ras_push,
   output logic             ras_pop,
   output logic [31:0]      ras_new_addr,
   output logic             ras_branch_fetched,
   output logic             ras_branch_retired,
   output logic             predict_return,
   output logic [CNT_W-1:0] outstanding
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_IDS);

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   logic             push_reg, push_next;
   logic             pop_reg, pop_next;
   logic             fetched_reg, fetched_next;
   logic             retired_reg, retired_next;
   logic             predict_reg, predict_next;
   logic [31:0]      addr_reg, addr_next;
   logic [CNT_W-1:0] count_reg, count_next;

   logic             flush;
   logic             accept;
   logic             rd_link;
   logic             rs1_link;
   logic             push_req;
   logic             pop_req;
   logic             cf_req;
   logic             retire_ok;
   logic [31:0]      ret_addr;

   assign fetch_ready = (count_reg < FULL);

   assign flush    = fetch_flush | early_flush;
   assign accept   = fetch_valid & fetch_ready & ~flush;
   assign rd_link  = is_link(rd_addr);
   assign rs1_link = is_link(rs1_addr);
   assign cf_req   = is_branch | is_jal | is_jalr;

   // JALR with both link registers pushes; it also pops unless rd == rs1 (coroutine swap).
   assign push_req = (is_jal & rd_link) | (is_jalr & rd_link);
   assign pop_req  = is_jalr & rs1_link & (~rd_link | (rd_addr != rs1_addr));

`ifdef RAS_CTRL_COMPRESSED_EN
   assign ret_addr = fetch_pc + (is_compressed ? 32'd2 : 32'd4);
`else
   assign ret_addr = fetch_pc + 32'd4;
`endif

   assign retire_ok = branch_retired & (count_reg != '0) & ~flush;

   always_comb begin
      push_next    = 1'b0;
      pop_next     = 1'b0;
      fetched_next = 1'b0;
      predict_next = 1'b0;
      retired_next = retire_ok;
      addr_next    = addr_reg;
      count_next   = count_reg;
      if (accept) begin
         push_next    = push_req;
         pop_next     = pop_req;
         predict_next = pop_req;
         fetched_next = cf_req;
         if (push_req) begin
            addr_next = ret_addr;
         end
      end
      if (flush) begin
         count_next = '0;
      end else begin
         unique case ({accept & cf_req, retire_ok})
            2'b10:   count_next = (count_reg == FULL) ? count_reg : count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         push_reg    <= 1'b0;
         pop_reg     <= 1'b0;
         fetched_reg <= 1'b0;
         retired_reg <= 1'b0;
         predict_reg <= 1'b0;
         addr_reg    <= '0;
         count_reg   <= '0;
      end else begin
         push_reg    <= push_next;
         pop_reg     <= pop_next;
         fetched_reg <= fetched_next;
         retired_reg <= retired_next;
         predict_reg <= predict_next;
         addr_reg    <= addr_next;
         count_reg   <= count_next;
      end
   end

   assign ras_push           = push_reg;
   assign ras_pop            = pop_reg;
   assign ras_new_addr       = addr_reg;
   assign ras_branch_fetched = fetched_reg;
   assign ras_branch_retired = retired_reg;
   assign predict_return     = predict_reg;
   assign outstanding        = count_reg;

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed vector table, multi-cycle sequences
// and randomized traffic against a behavioural model.
module tb_ras_ctrl;

   localparam int MAX = 8;

   typedef struct {
      logic        rst, fv;
      logic [31:0] pc;
      logic        br, jal, jalr;
      logic [4:0]  rd, rs1;
      logic        ret, ff, ef, cmp;
   } in_t;

   typedef struct {
      in_t         i;
      logic        rdy, push, pop, fet, pred, rtd;
      int          cnt;
      logic [31:0] addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, fetch_valid, fetch_ready;
   logic [31:0] fetch_pc;
   logic        is_branch, is_jal, is_jalr;
   logic [4:0]  rd_addr, rs1_addr;
   logic        branch_retired, fetch_flush, early_flush;
   logic        ras_push, ras_pop, ras_branch_fetched, ras_branch_retired, predict_return;
   logic [31:0] ras_new_addr;
   logic [3:0]  outstanding;
`ifdef RAS_CTRL_COMPRESSED_EN
   logic        is_compressed;
`endif

   ras_ctrl #(.MAX_IDS(MAX)) dut (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
      .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
      .rd_addr(rd_addr), .rs1_addr(rs1_addr),
`ifdef RAS_CTRL_COMPRESSED_EN
      .is_compressed(is_compressed),
`endif
      .branch_retired(branch_retired), .fetch_flush(fetch_flush), .early_flush(early_flush),
      .ras_push(ras_push), .ras_pop(ras_pop), .ras_new_addr(ras_new_addr),
      .ras_branch_fetched(ras_branch_fetched), .ras_branch_retired(ras_branch_retired),
      .predict_return(predict_return), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic last_rdy;

   // Behavioural model state
   int          m_cnt;
   logic        m_push, m_pop, m_fet, m_pred, m_rtd, m_rdy;
   logic [31:0] m_addr;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic push, input logic pop, input logic fet,
                             input logic pred, input logic rtd, input int cnt, input logic [31:0] addr);
      chk({tag, ".push"}, 32'(ras_push), 32'(push));
      chk({tag, ".pop"}, 32'(ras_pop), 32'(pop));
      chk({tag, ".fetched"}, 32'(ras_branch_fetched), 32'(fet));
      chk({tag, ".predict"}, 32'(predict_return), 32'(pred));
      chk({tag, ".retired"}, 32'(ras_branch_retired), 32'(rtd));
      chk({tag, ".outstanding"}, 32'(outstanding), 32'(cnt));
      chk({tag, ".new_addr"}, ras_new_addr, addr);
   endtask

   function automatic logic lk(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   function automatic in_t idle();
      in_t t = '{default: '0};
      return t;
   endfunction

   function automatic in_t rst_in();
      in_t t = idle();
      t.rst = 1'b1;
      return t;
   endfunction

   function automatic in_t br_op();
      in_t t = idle();
      t.fv = 1'b1; t.br = 1'b1; t.pc = 32'h0000_0800;
      return t;
   endfunction

   function automatic in_t jal_op(input logic [31:0] pc, input logic [4:0] rd);
      in_t t = idle();
      t.fv = 1'b1; t.jal = 1'b1; t.pc = pc; t.rd = rd;
      return t;
   endfunction

   function automatic in_t jalr_op(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1);
      in_t t = idle();
      t.fv = 1'b1; t.jalr = 1'b1; t.pc = pc; t.rd = rd; t.rs1 = rs1;
      return t;
   endfunction

   function automatic in_t w_ret(input in_t t);  in_t u = t; u.ret = 1'b1; return u; endfunction
   function automatic in_t w_ff(input in_t t);   in_t u = t; u.ff = 1'b1;  return u; endfunction
   function automatic in_t w_ef(input in_t t);   in_t u = t; u.ef = 1'b1;  return u; endfunction

   task automatic add(input in_t i, input logic rdy, input logic push, input logic pop, input logic fet,
                      input logic pred, input logic rtd, input int cnt, input logic [31:0] addr);
      vec_t v;
      v.i = i; v.rdy = rdy; v.push = push; v.pop = pop; v.fet = fet;
      v.pred = pred; v.rtd = rtd; v.cnt = cnt; v.addr = addr;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, advance the reference model, sample outputs 1 time unit after the edge.
   task automatic cycle(input in_t i);
      logic        flush, acc, p, q, vret;
      logic [31:0] ra;
      rst = i.rst; fetch_valid = i.fv; fetch_pc = i.pc;
      is_branch = i.br; is_jal = i.jal; is_jalr = i.jalr;
      rd_addr = i.rd; rs1_addr = i.rs1;
      branch_retired = i.ret; fetch_flush = i.ff; early_flush = i.ef;
`ifdef RAS_CTRL_COMPRESSED_EN
      is_compressed = i.cmp;
      ra = i.pc + (i.cmp ? 32'd2 : 32'd4);
`else
      ra = i.pc + 32'd4;
`endif
      #1;
      last_rdy = fetch_ready;
      m_rdy = (m_cnt < MAX);
      flush = i.ff | i.ef;
      acc = i.fv & m_rdy & !flush;
      p = 1'b0; q = 1'b0;
      if (acc && i.jal && lk(i.rd)) p = 1'b1;
      if (acc && i.jalr) begin
         if (lk(i.rd) && !lk(i.rs1)) p = 1'b1;
         else if (!lk(i.rd) && lk(i.rs1)) q = 1'b1;
         else if (lk(i.rd) && lk(i.rs1) && i.rd != i.rs1) begin p = 1'b1; q = 1'b1; end
         else if (lk(i.rd) && lk(i.rs1)) p = 1'b1;
      end
      vret = i.ret && (m_cnt > 0) && !flush;
      @(posedge clk);
      if (i.rst) begin
         m_push = 0; m_pop = 0; m_fet = 0; m_pred = 0; m_rtd = 0; m_cnt = 0; m_addr = '0;
      end else begin
         m_push = p; m_pop = q; m_pred = q;
         m_fet = acc & (i.br | i.jal | i.jalr);
         m_rtd = vret;
         if (p) m_addr = ra;
         m_cnt = flush ? 0 : m_cnt + int'(m_fet) - int'(vret);
      end
      #1;
   endtask

   task automatic do_reset();
      cycle(rst_in());
      cycle(rst_in());
   endtask

   initial begin
      in_t r;
      m_cnt = 0; m_addr = '0;
      do_reset();
      expect_out("reset", 0, 0, 0, 0, 0, 0, 32'h0);

      // Directed table: inputs, pre-edge ready, then registered outputs after the edge.
      add(jal_op(32'h1000, 5'd1),               1, 1, 0, 1, 0, 0, 1, 32'h1004);
      add(jalr_op(32'h1100, 5'd0, 5'd1),        1, 0, 1, 1, 1, 0, 2, 32'h1004);
      add(jalr_op(32'h1200, 5'd5, 5'd1),        1, 1, 1, 1, 1, 0, 3, 32'h1204);
      add(jalr_op(32'h1300, 5'd1, 5'd1),        1, 1, 0, 1, 0, 0, 4, 32'h1304);
      add(w_ret(br_op()),                       1, 0, 0, 1, 0, 1, 4, 32'h1304);
      add(jalr_op(32'h1340, 5'd2, 5'd3),        1, 0, 0, 1, 0, 0, 5, 32'h1304);
      add(w_ret(idle()),                        1, 0, 0, 0, 0, 1, 4, 32'h1304);
      add(jal_op(32'h1400, 5'd0),               1, 0, 0, 1, 0, 0, 5, 32'h1304);
      add(jalr_op(32'h1500, 5'd1, 5'd5),        1, 1, 1, 1, 1, 0, 6, 32'h1504);
      add(w_ff(jal_op(32'h1600, 5'd1)),         1, 0, 0, 0, 0, 0, 0, 32'h1504);
      add(w_ret(idle()),                        1, 0, 0, 0, 0, 0, 0, 32'h1504);
      add(jal_op(32'hFFFF_FFFC, 5'd1),          1, 1, 0, 1, 0, 0, 1, 32'h0000_0000);
      r = jal_op(32'h1700, 5'd1); r.fv = 1'b0;
      add(r,                                    1, 0, 0, 0, 0, 0, 1, 32'h0);
      add(w_ef(br_op()),                        1, 0, 0, 0, 0, 0, 0, 32'h0);
      add(br_op(),                              1, 0, 0, 1, 0, 0, 1, 32'h0);
      add(w_ff(w_ret(idle())),                  1, 0, 0, 0, 0, 0, 0, 32'h0);
      add(jalr_op(32'h1800, 5'd5, 5'd5),        1, 1, 0, 1, 0, 0, 1, 32'h1804);

      for (int k = 0; k < vecs.size(); k++) begin
         cycle(vecs[k].i);
         chk($sformatf("vec%0d.ready", k), 32'(last_rdy), 32'(vecs[k].rdy));
         expect_out($sformatf("vec%0d", k), vecs[k].push, vecs[k].pop, vecs[k].fet,
                    vecs[k].pred, vecs[k].rtd, vecs[k].cnt, vecs[k].addr);
         $display("vector %0d pc=%h push=%0b pop=%0b fetched=%0b retired=%0b outstanding=%0d",
                  k, vecs[k].i.pc, ras_push, ras_pop, ras_branch_fetched, ras_branch_retired, outstanding);
      end

      // Fill to MAX_IDS, hold the ninth offer, release with one retire.
      do_reset();
      for (int k = 0; k < MAX; k++) begin
         cycle(br_op());
         chk("fill.ready", 32'(last_rdy), 32'd1);
         chk("fill.cnt", 32'(outstanding), 32'(k + 1));
      end
      cycle(br_op());
      chk("full.ready", 32'(last_rdy), 32'd0);
      expect_out("full.held", 0, 0, 0, 0, 0, MAX, 32'h0);
      cycle(w_ret(br_op()));
      chk("full.ret_ready", 32'(last_rdy), 32'd0);
      expect_out("full.retire", 0, 0, 0, 0, 1, MAX - 1, 32'h0);
      cycle(br_op());
      chk("full.reaccept_ready", 32'(last_rdy), 32'd1);
      expect_out("full.reaccept", 0, 0, 1, 0, 0, MAX, 32'h0);
      $display("sequence fill: outstanding=%0d", outstanding);

      // Simultaneous accept and retire at 3 keeps the count.
      do_reset();
      for (int k = 0; k < 3; k++) cycle(br_op());
      cycle(w_ret(br_op()));
      expect_out("both", 0, 0, 1, 0, 1, 3, 32'h0);
      $display("sequence accept+retire: outstanding=%0d", outstanding);

      // Flush and early flush against a JAL offer after four branches.
      for (int f = 0; f < 2; f++) begin
         do_reset();
         for (int k = 0; k < 4; k++) cycle(br_op());
         chk("preflush.cnt", 32'(outstanding), 32'd4);
         r = jal_op(32'h2400, 5'd1);
         if (f == 0) r.ff = 1'b1; else r.ef = 1'b1;
         cycle(r);
         expect_out(f == 0 ? "fetch_flush" : "early_flush", 0, 0, 0, 0, 0, 0, 32'h0);
         $display("sequence flush%0d: outstanding=%0d", f, outstanding);
      end

      // Reset mid-operation zeroes the return address too.
      do_reset();
      cycle(jal_op(32'h3000, 5'd1));
      expect_out("pre_rst", 1, 0, 1, 0, 0, 1, 32'h3004);
      r = jal_op(32'h4000, 5'd1); r.rst = 1'b1;
      cycle(r);
      expect_out("mid_rst", 0, 0, 0, 0, 0, 0, 32'h0);
      $display("sequence mid-reset: new_addr=%h", ras_new_addr);

`ifdef RAS_CTRL_COMPRESSED_EN
      r = jal_op(32'h2000, 5'd1); r.cmp = 1'b1;
      cycle(r);
      expect_out("compressed", 1, 0, 1, 0, 0, 1, 32'h2002);
      $display("sequence compressed: new_addr=%h", ras_new_addr);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 800; n++) begin
         in_t t;
         int kind;
         t = idle();
         t.rst = ($urandom_range(0, 199) == 0);
         t.fv  = ($urandom_range(0, 9) < 7);
         t.pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
         kind  = $urandom_range(0, 3);
         t.br  = (kind == 1); t.jal = (kind == 2); t.jalr = (kind == 3);
         case ($urandom_range(0, 3))
            0: t.rd = 5'd1;  1: t.rd = 5'd5;  2: t.rd = 5'd0;  default: t.rd = 5'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: t.rs1 = 5'd1; 1: t.rs1 = 5'd5; 2: t.rs1 = 5'd0; default: t.rs1 = 5'($urandom);
         endcase
         t.ret = ($urandom_range(0, 9) < 3);
         t.ff  = ($urandom_range(0, 39) == 0);
         t.ef  = ($urandom_range(0, 39) == 0);
         t.cmp = 1'($urandom);
         cycle(t);
         chk("rand.ready", 32'(last_rdy), 32'(m_rdy));
         expect_out("rand", m_push, m_pop, m_fet, m_pred, m_rtd, m_cnt, m_addr);
         $display("txn %0d fv=%0b k=%0d rd=%0d rs1=%0d ret=%0b fl=%0b push=%0b pop=%0b cnt=%0d addr=%h",
                  n, t.fv, kind, t.rd, t.rs1, t.ret, t.ff | t.ef, ras_push, ras_pop, outstanding, ras_new_addr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Sequencing controller for the return address stack (RAS), placed between fetch/decode and the RAS.
- Classifies each accepted control-flow instruction as call, return, coroutine swap or plain branch.
- Generates registered RAS push/pop/new-address and checkpoint push/retire strobes.
- Tracks outstanding speculative checkpoints and back-pressures fetch when the checkpoint FIFO would overflow.

Parameters:
- MAX_IDS, 8: RAS checkpoint FIFO depth; maximum outstanding speculative control-flow instructions.
- CNT_W, $clog2(MAX_IDS+1): outstanding-counter width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_valid  in  1  decoded instruction offered
- fetch_ready  out  1  controller can accept the offered instruction
- fetch_pc  in  32  PC of offered instruction
- is_branch  in  1  conditional branch
- is_jal  in  1  JAL
- is_jalr  in  1  JALR
- rd_addr  in  5  destination register
- rs1_addr  in  5  source register 1
- branch_retired  in  1  oldest outstanding control-flow instruction retired
- fetch_flush  in  1  global fetch flush (misprediction/exception)
- early_flush  in  1  early branch flush; checkpoint FIFO is reset
- ras_push  out  1  push return address
- ras_pop  out  1  pop return address
- ras_new_addr  out  32  address to push
- ras_branch_fetched  out  1  save checkpoint
- ras_branch_retired  out  1  release oldest checkpoint
- predict_return  out  1  RAS top is valid return prediction this cycle
- outstanding  out  CNT_W  current checkpoint count

Behaviour:
- Reset values: all outputs 0; outstanding = 0.
- Accept condition: accept = fetch_valid & fetch_ready & !fetch_flush & !early_flush.
- fetch_ready = (outstanding < MAX_IDS), combinational.
- Link register: link(x) = (x == 1) | (x == 5).
- Classification, evaluated on accept:
  - JAL with link(rd): push.
  - JALR with link(rd) & !link(rs1): push.
  - JALR with !link(rd) & link(rs1): pop.
  - JALR with link(rd) & link(rs1) & rd != rs1: pop and push in the same cycle (coroutine).
  - JALR with link(rd) & link(rs1) & rd == rs1: push only.
  - Anything else: no RAS op.
- Checkpoint strobe: cf = is_branch | is_jal | is_jalr.
- Output timing: every RAS output is registered, so an accept in cycle N produces its strobes in cycle N+1.
  - ras_push, ras_pop, ras_branch_fetched (= cf) and predict_return (= pop) are single-cycle pulses.
  - ras_new_addr = fetch_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). It holds its value when no push is issued.
- Retire path:
  - ras_branch_retired is registered: branch_retired & (outstanding_effective > 0).
  - A retire with count 0 is dropped and produces no pulse.
- Outstanding counter:
  - +1 on an accepted cf.
  - -1 on a valid retire.
  - Both in the same cycle: unchanged.
  - Saturates at MAX_IDS; it cannot pass this because fetch_ready is low when full.
  - Retire at full in the same cycle as a new offer: ready is still low that cycle and the offer is accepted the next cycle.
- Flush:
  - fetch_flush or early_flush forces outstanding to 0 next cycle.
  - The registered push, pop, fetched and predict strobes are cleared next cycle, and any offered instruction that cycle is discarded.
  - A ras_branch_retired already registered in the flush cycle is suppressed.
  - A flush has priority over accept and retire in the same cycle.
- Reset mid-operation: same effect as a flush, plus ras_new_addr is zeroed.

Optional Feature:
- Macro: RAS_CTRL_COMPRESSED_EN.
- Defined: adds input port is_compressed (1 bit).
  - ras_new_addr = fetch_pc + 2 when is_compressed, otherwise fetch_pc + 4.
  - c.jal/c.jalr/c.jr arrive with rd/rs1 already expanded and are classified identically.
- Undefined: the port is absent and the return address is always fetch_pc + 4.

Test Plan:
- After reset, accept JAL rd=x1 at pc 0x1000 → next cycle ras_push=1, ras_new_addr=0x1004, ras_branch_fetched=1, outstanding=1.
- JALR rd=x0 rs1=x1 → ras_pop=1, predict_return=1, ras_push=0. Then JALR rd=x5 rs1=x1 → ras_push=1 and ras_pop=1 in the same cycle. Then JALR rd=x1 rs1=x1 → push only.
- MAX_IDS=8: issue 8 conditional branches with no retire → outstanding=8, fetch_ready=0, ninth offer held. One retire → ready returns the following cycle and the ninth branch is accepted.
- Accept a branch and a retire in the same cycle at outstanding=3 → remains 3. Retire at outstanding=0 → no ras_branch_retired pulse.
- Accept 4 branches, then fetch_flush in the same cycle as a JAL offer → no push/fetched pulse, outstanding=0. Repeat with early_flush → same result.
- JAL rd=x1 at pc 0xFFFFFFFC → ras_new_addr=0x00000000. With RAS_CTRL_COMPRESSED_EN and is_compressed=1 at pc 0x2000 → ras_new_addr=0x2002.
